// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//
// Decoupling buffer between the fetch stage and the decode stage. This is a
// small circular FIFO of {inst, pc, pc4} bundles with a valid/ready handshake
// on both sides. A taken branch or jump asserts flush, which empties the
// queue. While the queue is empty, decode sees a NOP bubble rather than
// stale storage contents.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      discard all buffered entries (PCSel of a taken branch)
//   in_valid   fetch presents a bundle this cycle
//   in_ready   queue can accept a bundle (registered state only)
//   in_inst    fetched instruction
//   in_pc      address of in_inst
//   in_pc4     in_pc + 4
//   out_valid  head entry valid
//   out_ready  decode consumes the head this cycle
//   out_inst   head instruction, or NOP_INST when empty
//   out_pc     head pc, or 0 when empty
//   out_pc4    head pc4, or 0 when empty
//   count      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int          DEPTH    = 2,
  parameter int          PTR_W    = $clog2(DEPTH),
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_pc4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc4,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      pc4_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;

  logic             push;
  logic             pop;

  // Handshakes come purely from registered occupancy, so there is no
  // combinational path from out_ready to in_ready. At full, a same-cycle
  // pop therefore cannot make room for a push.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid  & in_ready;
  assign pop  = out_valid & out_ready;

  // Head read is combinational. An empty queue shows a NOP bubble.
  assign out_inst = out_valid ? inst_mem[rd_ptr] : NOP_INST;
  assign out_pc   = out_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign out_pc4  = out_valid ? pc4_mem[rd_ptr]  : 32'h0;

  // Pointer and occupancy state. Flush wins over any same-cycle push or pop.
  // Because DEPTH is a power of two, the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage has no reset. Contents are only observed while count says the
  // slot is occupied. Writes are suppressed on flush, so a discarded push
  // leaves no trace.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
      pc4_mem[wr_ptr]  <= in_pc4;
    end
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between the fetch stage (inst/pc/pc4 producer) and the decode stage.
- A small circular FIFO of fetched instruction bundles, with a valid/ready handshake on both sides.
- A flush input discards all buffered entries on a taken branch/jump (PCSel).
- When the queue is empty, decode sees a NOP bubble instead of stale data.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- PTR_W, log2(DEPTH), read/write pointer width.
- NOP_INST, 32'h0000_0013, encoding presented on out_inst when empty (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all entries (driven by PCSel of a taken branch)
- in_valid  in  1  fetch presents a bundle this cycle
- in_ready  out  1  queue can accept a bundle
- in_inst  in  32  fetched instruction
- in_pc  in  32  address of in_inst
- in_pc4  in  32  in_pc + 4
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head this cycle
- out_inst  out  32  head instruction, or NOP_INST when empty
- out_pc  out  32  head pc, or 0 when empty
- out_pc4  out  32  head pc4, or 0 when empty
- count  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - out_valid = 0, in_ready = 1.
  - out_inst = NOP_INST, out_pc = 0, out_pc4 = 0.
  - Storage array contents are don't-care.
- Handshake signals:
  - in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - Outputs are combinational reads of the head entry.
- Transfer rules:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Push writes {inst,pc,pc4} at wr_ptr; wr_ptr increments modulo DEPTH.
  - Pop increments rd_ptr modulo DEPTH.
- Occupancy update:
  - push & !pop: count + 1.
  - pop & !push: count - 1.
  - Both or neither: count unchanged.
- Latency: a bundle pushed in cycle N is visible on out_* in cycle N+1 (one-cycle latency, no bypass).
- Full case: in_ready = 0, so a simultaneous pop does not enable a push that cycle. Throughput at full is one entry per cycle only after count drops.
- Empty case:
  - out_valid = 0 and out_inst = NOP_INST.
  - out_ready is ignored; count never underflows.
- Pointer wrap: pointers wrap at DEPTH naturally; count disambiguates full from empty.
- Flush (synchronous, highest priority):
  - On a cycle with flush = 1, the next state is wr_ptr = rd_ptr = 0 and count = 0.
  - Any same-cycle push and pop are discarded; the pop is not counted as delivered to the queue state.
  - Decode must itself squash the head it sampled in a flush cycle.
  - The cycle after a flush, out_valid = 0.
  - The redirect-target instruction fetched in the next cycle is pushed normally.
- Reset mid-operation: asynchronous reset returns all state to reset values immediately, regardless of clk.
- Data stability: the head entry is stable while out_valid = 1 and out_ready = 0.

Test Plan:
- Reset, then single push: rst_n low → high. Push inst=32'h00500093, pc=0, pc4=4 → next cycle out_valid=1, out_inst=32'h00500093, out_pc=0, out_pc4=4, count=1.
- Fill then backpressure: out_ready=0, push pc=0x0 and pc=0x4 → count=2, in_ready=0. A third in_valid with pc=0x8 is not accepted. Then out_ready=1 for one cycle → head becomes pc=0x4, count=1, in_ready=1.
- Streaming: in_valid=1 and out_ready=1 continuously from count=1, pcs 0x0, 0x4, 0x8 … → count stays 1. out_pc sequence is 0x0, 0x4, 0x8 … with one-cycle lag. Pointers wrap past DEPTH without loss.
- Empty bubble: count=0, out_ready=1 → out_valid=0, out_inst=32'h00000013, out_pc=0; count stays 0.
- Flush with simultaneous push: count=2, flush=1, in_valid=1 (pc=0x40) → next cycle count=0, out_valid=0. Push pc=0x80 the cycle after → out_pc=0x80.
- Async reset mid-stream: count=2, drop rst_n between clock edges → out_valid=0, count=0, in_ready=1 before the next edge.
